// File: rtl/swc_out_sched_if.sv
// Scheduler-side bundle between the out-scheduler, the queue controllers,
// the output cell FIFOs and the SRAM read engine.
interface swc_out_sched_if #(
    parameter int NPORT = 4,
    parameter int WW    = 4,
    parameter int CW    = (NPORT > 1) ? $clog2(NPORT) : 1
);
    logic [NPORT-1:0]    ptr_rdy;
    logic [NPORT-1:0]    o_cell_bp;
    logic [NPORT*WW-1:0] cfg_weight;
    logic                grant_vld;
    logic [NPORT-1:0]    grant;
    logic [NPORT-1:0]    ptr_ack;
    logic                eng_done;
    logic [CW-1:0]       cur_port;
    logic                err_tmo;

    // Scheduler side: issues grants, consumes readiness and completion.
    modport master (
        input  ptr_rdy, o_cell_bp, cfg_weight, eng_done,
        output grant_vld, grant, ptr_ack, cur_port, err_tmo
    );

    // Queue controllers / read engine side.
    modport slave (
        output ptr_rdy, o_cell_bp, cfg_weight, eng_done,
        input  grant_vld, grant, ptr_ack, cur_port, err_tmo
    );
endinterface

// File: rtl/swc_out_sched.sv
// Weighted round-robin cell scheduler for the switch core read side.
// One grant outstanding at a time; a port keeps the grant for up to its
// weight in cells per visit, then the scan moves on to the next eligible port.
module swc_out_sched #(
    parameter int NPORT = 4,
    parameter int WW    = 4,
    parameter int TMO   = 64
) (
    input  logic            clk,
    input  logic            rstn,
    swc_out_sched_if.master bus
);
    localparam int CW  = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int TCW = $clog2(TMO);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    credit_q, credit_d;
    logic [CW-1:0]    cur_port_q, cur_port_d;
    logic [NPORT-1:0] grant_q, grant_d;
    logic [TCW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic             err_tmo_q, err_tmo_d;

    logic [NPORT-1:0] elig;
    logic [CW-1:0]    scan_port;
    logic [WW-1:0]    weight_sel;
    logic             grant_vld;

    // Port is eligible when it has a head pointer, no back-pressure and a non-zero weight.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        elig = '0;
        for (int i = 0; i < NPORT; i++) begin
            elig[i] = bus.ptr_rdy[i] & ~bus.o_cell_bp[i] & (bus.cfg_weight[WW*i +: WW] != '0);
        end
    end

    // Round-robin scan: nearest eligible port after cur_port, cur_port itself last.
    always_comb begin
        int base;
        scan_port = cur_port_q;
        // Walking from farthest to nearest lets the nearest eligible port overwrite the rest.
        for (int i = NPORT; i >= 1; i--) begin
            if (elig[(int'(cur_port_q) + i) % NPORT]) begin
                scan_port = CW'((int'(cur_port_q) + i) % NPORT);
            end
        end
        base       = WW * int'(scan_port);
        weight_sel = bus.cfg_weight[base +: WW];
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            cur_port_q <= '0;
            grant_q    <= '0;
            tmo_cnt_q  <= '0;
            err_tmo_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            credit_q   <= credit_d;
            cur_port_q <= cur_port_d;
            grant_q    <= grant_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    // Next-state and credit/timeout bookkeeping.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        cur_port_d = cur_port_q;
        grant_d    = grant_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_tmo_d  = err_tmo_q;
        unique case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    state_d = GRANT;
                    if (elig[cur_port_q] && credit_q != '0) begin
                        // Continue the burst on the current port.
                        credit_d = credit_q - WW'(1);
                        grant_d  = NPORT'(1) << cur_port_q;
                    end else begin
                        // New visit: this grant consumes one cell of the fresh weight.
                        credit_d   = weight_sel - WW'(1);
                        cur_port_d = scan_port;
                        grant_d    = NPORT'(1) << scan_port;
                    end
                end
            end
            GRANT: begin
                // The grant cycle is cycle 0 of the timeout window.
                tmo_cnt_d = TCW'(1);
                state_d   = WAIT;
            end
            WAIT: begin
                if (bus.eng_done) begin
                    state_d = IDLE;
                end else if (tmo_cnt_q == TCW'(TMO - 1)) begin
                    err_tmo_d = 1'b1;
                    credit_d  = '0;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grant pulse decoded from the state, everything else straight from flops.
    always_comb begin
        grant_vld     = (state_q == GRANT);
        bus.grant_vld = grant_vld;
        bus.grant     = grant_q;
        bus.ptr_ack   = grant_q & {NPORT{grant_vld}};
        bus.cur_port  = cur_port_q;
        bus.err_tmo   = err_tmo_q;
    end
endmodule

// File: tb/tb_swc_out_sched.sv
// Self-checking bench for swc_out_sched: directed scenarios followed by a
// randomized run, all compared against a behavioural WRR model.
module tb_swc_out_sched;
    localparam int NPORT = 4;
    localparam int WW    = 4;
    localparam int TMO   = 64;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    swc_out_sched_if #(.NPORT(NPORT), .WW(WW)) bus ();

    swc_out_sched #(.NPORT(NPORT), .WW(WW), .TMO(TMO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which port is being visited, cells left in this visit, sticky error.
    int m_cur    = 0;
    int m_credit = 0;
    bit m_err    = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int weight_of(input int p);
        return int'(bus.cfg_weight[p*WW +: WW]);
    endfunction

    // Decide the next grant from the current inputs; -1 when nobody can be served.
    function automatic int model_pick();
        bit elig [NPORT];
        bit any = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            elig[i] = bus.ptr_rdy[i] && !bus.o_cell_bp[i] && (weight_of(i) != 0);
            any     = any || elig[i];
        end
        if (!any) return -1;
        if (elig[m_cur] && m_credit > 0) begin
            m_credit = m_credit - 1;
            return m_cur;
        end
        for (int k = 1; k <= NPORT; k++) begin
            int p;
            p = (m_cur + k) % NPORT;
            if (elig[p]) begin
                m_cur    = p;
                m_credit = weight_of(p) - 1;
                return p;
            end
        end
        return -1;
    endfunction

    // Called one sample after the DUT could have left IDLE; checks the pulse and, when
    // a grant happened, also the cycle after it (pulse must be single-cycle).
    task automatic check_grant(input string tag, output int port);
        port = model_pick();
        if (port < 0) begin
            check({tag, "_idle"}, bus.grant_vld, 1'b0);
            check({tag, "_idle_ack"}, bus.ptr_ack, 4'h0);
        end else begin
            check({tag, "_vld"}, bus.grant_vld, 1'b1);
            check({tag, "_grant"}, bus.grant, 32'(1) << port);
            check({tag, "_ack"}, bus.ptr_ack, 32'(1) << port);
            check({tag, "_ack_bits"}, $countones(bus.ptr_ack), 1);
            check({tag, "_cur"}, bus.cur_port, port);
            check({tag, "_err"}, bus.err_tmo, m_err);
            tick();
            check({tag, "_pulse_end"}, bus.grant_vld, 1'b0);
            check({tag, "_ack_end"}, bus.ptr_ack, 4'h0);
            check({tag, "_hold"}, bus.grant, 32'(1) << port);
        end
    endtask

    // From the first WAIT sample, raise eng_done d cycles after the grant and step to
    // the sample where the next grant is due.
    task automatic finish_txn(input string tag, input int d);
        for (int i = 1; i < d; i++) begin
            tick();
            check({tag, "_quiet"}, bus.grant_vld, 1'b0);
        end
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        check({tag, "_gap"}, bus.grant_vld, 1'b0);
        tick();
    endtask

    task automatic randomize_inputs();
        bus.ptr_rdy    = NPORT'($urandom);
        bus.o_cell_bp  = NPORT'($urandom & $urandom);
        bus.cfg_weight = (NPORT*WW)'($urandom);
    endtask

    initial begin
        int p;
        int cnt [NPORT];
        logic [NPORT-1:0] t1_exp [5];
        t1_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        // Reset state
        rstn           = 1'b0;
        bus.ptr_rdy    = 4'hF;
        bus.o_cell_bp  = 4'h0;
        bus.cfg_weight = 16'h1111;
        bus.eng_done   = 1'b0;
        tick();
        tick();
        check("rst_vld", bus.grant_vld, 1'b0);
        check("rst_grant", bus.grant, 4'h0);
        check("rst_ack", bus.ptr_ack, 4'h0);
        check("rst_cur", bus.cur_port, 2'd0);
        check("rst_err", bus.err_tmo, 1'b0);
        rstn = 1'b1;
        tick();

        // Equal weights: strict rotation starting from port 1
        for (int i = 0; i < 5; i++) begin
            check_grant("t1", p);
            check("t1_seq", bus.grant, t1_exp[i]);
            if (i == 4) bus.cfg_weight = 16'h2013;  // weights 3,1,0,2 for ports 0..3
            finish_txn("t1", 2);
        end

        // Weighted rounds: port3 x2, port0 x3, port1 x1, port2 masked
        for (int i = 0; i < NPORT; i++) cnt[i] = 0;
        for (int i = 0; i < 12; i++) begin
            check_grant("t2", p);
            for (int j = 0; j < NPORT; j++) if (bus.grant[j]) cnt[j]++;
            if (i == 11) begin
                bus.ptr_rdy   = 4'b0010;
                bus.o_cell_bp = 4'b0010;
            end
            finish_txn("t2", 1 + (i % 3));
        end
        check("t2_cnt0", cnt[0], 6);
        check("t2_cnt1", cnt[1], 2);
        check("t2_cnt2", cnt[2], 0);
        check("t2_cnt3", cnt[3], 4);

        // Back-pressure holds off the only ready port; eng_done while idle is ignored
        check_grant("t3_bp", p);
        tick();
        check_grant("t3_bp2", p);
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        check_grant("t3_stray_done", p);
        bus.o_cell_bp = 4'h0;
        tick();
        check_grant("t3_release", p);
        check("t3_port1", bus.grant, 4'b0010);
        bus.ptr_rdy    = 4'hF;
        bus.cfg_weight = 16'h1111;
        finish_txn("t3", 2);

        // eng_done on the very last cycle of the window counts as done
        check_grant("t4a", p);
        finish_txn("t4a", TMO - 1);
        check_grant("t4a_next", p);

        // No eng_done: error exactly TMO cycles after the grant, then grants resume
        for (int i = 0; i < TMO - 2; i++) begin
            tick();
            check("t4_quiet", bus.grant_vld, 1'b0);
        end
        check("t4_err_before", bus.err_tmo, 1'b0);
        tick();
        check("t4_err_at_tmo", bus.err_tmo, 1'b1);
        m_err    = 1'b1;
        m_credit = 0;
        tick();
        check_grant("t4_regrant", p);

        // Asynchronous reset mid-WAIT
        tick();
        rstn = 1'b0;
        #1;
        check("t6_vld", bus.grant_vld, 1'b0);
        check("t6_grant", bus.grant, 4'h0);
        check("t6_ack", bus.ptr_ack, 4'h0);
        check("t6_cur", bus.cur_port, 2'd0);
        check("t6_err", bus.err_tmo, 1'b0);
        m_cur    = 0;
        m_credit = 0;
        m_err    = 1'b0;
        bus.ptr_rdy = 4'b1001;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        check_grant("t6_first", p);
        check("t6_port3", bus.grant, 4'b1000);
        finish_txn("t6", 2);

        // Randomized traffic, inputs changed both in WAIT and while idle
        for (int it = 0; it < 60; it++) begin
            p = -1;
            for (int t = 0; t < 6 && p < 0; t++) begin
                check_grant("rnd", p);
                if (p < 0) begin
                    randomize_inputs();
                    tick();
                end
            end
            if (p < 0) begin
                bus.ptr_rdy    = 4'hF;
                bus.o_cell_bp  = 4'h0;
                bus.cfg_weight = 16'h1111;
                tick();
                check_grant("rnd_force", p);
            end
            if ($urandom_range(0, 1) == 1) randomize_inputs();
            finish_txn("rnd", int'($urandom_range(1, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
